// File: rtl/scan_decoder_n.sv
// scan_decoder_n: N-to-2**N one-hot decoder with registered outputs and an internal scan counter.
// Latency: y, sel and wrap update on the clock edge that samples the inputs (one cycle to visible).
// Backpressure: none; the scan free-runs at one step per PRESCALE cycles while UP/DOWN is held.
//
// Ports:
//   clk    in   1       rising-edge clock
//   reset  in   1       synchronous, active-high reset (priority over all inputs)
//   en     in   1       1 = outputs active / counter may run; 0 = outputs blanked, state frozen
//   mode   in   2       00 HOLD, 01 UP, 10 DOWN, 11 LOAD
//   a      in   N       index used when mode = LOAD
//   y      out  2**N    registered one-hot output, y[sel] = 1 when en = 1, else all zero
//   sel    out  N       registered current index
//   wrap   out  1       registered one-cycle pulse on counter wrap-around

module scan_decoder_n #(
   parameter int N        = 2,
   parameter int PRESCALE = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [N-1:0]        a,
   output logic [(2**N)-1:0]   y,
   output logic [N-1:0]        sel,
   output logic                wrap
);

   localparam int OUTS = 2**N;
   localparam int PCW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [PCW-1:0] PC_LAST  = PCW'(PRESCALE - 1);
   localparam logic [N-1:0]   SEL_MAX  = {N{1'b1}};
   localparam logic [N-1:0]   SEL_ZERO = {N{1'b0}};

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   logic [N-1:0]    r_sel;
   logic [OUTS-1:0] r_y;
   logic            r_wrap;
   logic [PCW-1:0]  r_pc;

   logic            w_scan;
   logic            w_step;
   logic            w_wrap_next;
   logic [N-1:0]    w_sel_next;
   logic [PCW-1:0]  w_pc_next;
   logic [OUTS-1:0] w_y_next;

   always_comb begin
      // Prescaler only runs while actively scanning; any other condition restarts the count,
      // so the first step always lands PRESCALE cycles after scanning (re)starts.
      w_scan = en && ((mode == MODE_UP) || (mode == MODE_DOWN));
      w_step = w_scan && (r_pc == PC_LAST);

      w_pc_next = '0;
      if (w_scan && !w_step) begin
         w_pc_next = r_pc + PCW'(1);
      end

      w_sel_next  = r_sel;
      w_wrap_next = 1'b0;
      if (en) begin
         case (mode)
            MODE_LOAD: w_sel_next = a;
            MODE_UP: begin
               if (w_step) begin
                  w_sel_next  = r_sel + N'(1);
                  w_wrap_next = (r_sel == SEL_MAX);
               end
            end
            MODE_DOWN: begin
               if (w_step) begin
                  w_sel_next  = r_sel - N'(1);
                  w_wrap_next = (r_sel == SEL_ZERO);
               end
            end
            MODE_HOLD: w_sel_next = r_sel;
            default:   w_sel_next = r_sel;
         endcase
      end

      // Decode the next index, not the current one, so y and sel move together.
      w_y_next             = '0;
      w_y_next[w_sel_next] = en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel  <= '0;
         r_y    <= '0;
         r_wrap <= 1'b0;
         r_pc   <= '0;
      end else begin
         r_sel  <= w_sel_next;
         r_y    <= w_y_next;
         r_wrap <= w_wrap_next;
         r_pc   <= w_pc_next;
      end
   end

   assign y    = r_y;
   assign sel  = r_sel;
   assign wrap = r_wrap;

   a_y_onehot0 : assert property (@(posedge clk) $onehot0(r_y));

endmodule
